// File: rtl/obc_dft_bit_sequencer.sv
// Bit-serial OBC controller for one 16-point DFT bin: loads 16 samples, issues bit-planes LSB first,
// shift-accumulates the ROM-bank sum. Define OBC_SEQ_ROUND_EN for half-up rounding on shifting updates.
`timescale 1ns/1ps
module obc_dft_bit_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ROM_W   = 32,
    parameter int ROM_LAT = 0,
    localparam int ACC_W  = ROM_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [15:0]       x_bits,
    output logic              x_valid,
    input  logic [ROM_W-1:0]  rom_sum,
    input  logic [ROM_W-1:0]  rom_offset,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // m_valid/m_data stay stable until that transfer, and rst overrides any transfer.

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);
    localparam logic [1:0]    DLAST = 2'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);

    typedef enum logic [1:0] {LOAD = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

    state_t                   state;
    logic [DATA_W-1:0]        slot    [16];
    logic [DATA_W-1:0]        slot_in [16];
    logic [3:0]               cnt;
    logic [BW-1:0]            bidx;
    logic [BW-1:0]            bidx_nx;
    logic [1:0]               dcnt;
    logic [15:0]              plane_first;
    logic [15:0]              plane_next;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  rsx;
    logic signed [ACC_W-1:0]  osx;
    logic signed [ACC_W-1:0]  ssum;
    logic signed [ACC_W-1:0]  ssum_r;
    logic                     act_v;
    logic [BW-1:0]            act_b;

    assign dbg_state = state;
    assign bidx_nx   = bidx + BW'(1);

    // The first plane must include the sample being accepted into slot 15 this cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            slot_in[i] = (state == LOAD && s_valid && cnt == 4'(i)) ? s_data : slot[i];
        end
        plane_first = '0;
        plane_next  = '0;
        for (int i = 0; i < 16; i++) begin
            plane_first[i] = slot_in[i][0];
            plane_next[i]  = slot[i][bidx_nx];
        end
    end

    generate
        if (ROM_LAT == 0) begin : g_nolat
            assign act_v = x_valid;
            assign act_b = bidx;
        end else begin : g_lat
            logic [ROM_LAT-1:0] pv;
            logic [BW-1:0]      pb [ROM_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                    for (int k = 0; k < ROM_LAT; k++) pb[k] <= '0;
                end else begin
                    pv[0] <= x_valid;
                    pb[0] <= bidx;
                    for (int k = 1; k < ROM_LAT; k++) begin
                        pv[k] <= pv[k-1];
                        pb[k] <= pb[k-1];
                    end
                end
            end
            assign act_v = pv[ROM_LAT-1];
            assign act_b = pb[ROM_LAT-1];
        end
    endgenerate

    always_comb begin
        rsx  = {{(ACC_W-ROM_W){rom_sum[ROM_W-1]}}, rom_sum};
        osx  = {{(ACC_W-ROM_W){rom_offset[ROM_W-1]}}, rom_offset};
        ssum = acc + rsx;
`ifdef OBC_SEQ_ROUND_EN
        ssum_r = ssum + {{(ACC_W-1){1'b0}}, ssum[0]};
`else
        ssum_r = ssum;
`endif
        acc_next = acc;
        if (act_v) begin
            if (act_b == BLAST) acc_next = acc - rsx + osx;
            else                acc_next = ssum_r >>> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            cnt     <= '0;
            bidx    <= '0;
            dcnt    <= '0;
            acc     <= '0;
            s_ready <= 1'b1;
            x_bits  <= '0;
            x_valid <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
        end else begin
            acc <= acc_next;
            case (state)
                LOAD: begin
                    if (s_valid) begin
                        slot[cnt] <= s_data;
                        cnt       <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state   <= ISSUE;
                            s_ready <= 1'b0;
                            busy    <= 1'b1;
                            x_valid <= 1'b1;
                            x_bits  <= plane_first;
                            bidx    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (bidx == BLAST) begin
                        x_valid <= 1'b0;
                        if (ROM_LAT > 0) begin
                            state <= DRAIN;
                            dcnt  <= '0;
                        end else begin
                            state   <= OUT;
                            m_valid <= 1'b1;
                            m_data  <= acc_next;
                        end
                    end else begin
                        bidx   <= bidx_nx;
                        x_bits <= plane_next;
                    end
                end
                DRAIN: begin
                    if (dcnt == DLAST) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                        m_data  <= acc_next;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        state   <= LOAD;
                        m_valid <= 1'b0;
                        acc     <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_obc_dft_bit_sequencer.sv
// Directed bench for obc_dft_bit_sequencer: a ROM_LAT=0 and a ROM_LAT=3 instance driven in lockstep,
// each result compared against a bit-serial reference model of the bin equations.
`timescale 1ns/1ps
module tb_obc_dft_bit_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        m_ready = 1'b1;
    logic [31:0] rom_offset = '0;
    logic        mode = 1'b0;
    logic [31:0] csum = '0;

    logic        s_ready0, x_valid0, m_valid0, busy0;
    logic        s_ready3, x_valid3, m_valid3, busy3;
    logic [15:0] x_bits0, x_bits3;
    logic [31:0] rom_sum0, rom_sum3;
    logic [33:0] m_data0, m_data3;
    logic [1:0]  st0, st3;
    logic [31:0] rpipe [3];

    logic [15:0] tb_slot [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    obc_dft_bit_sequencer #(.DATA_W(16), .ROM_W(32), .ROM_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .x_bits(x_bits0), .x_valid(x_valid0), .rom_sum(rom_sum0), .rom_offset(rom_offset),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .busy(busy0), .dbg_state(st0)
    );

    obc_dft_bit_sequencer #(.DATA_W(16), .ROM_W(32), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
        .x_bits(x_bits3), .x_valid(x_valid3), .rom_sum(rom_sum3), .rom_offset(rom_offset),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3), .busy(busy3), .dbg_state(st3)
    );

    // ROM bank model: either a constant sum or a weighted sum of the set x bits.
    function automatic logic [31:0] coef(input int i);
        logic [31:0] v;
        v = 32'h0135_7900 ^ (32'(i) * 32'h0102_0304);
        return (i % 2 == 1) ? -v : v;
    endfunction

    function automatic logic [31:0] rom_fn(input logic [15:0] x, input logic md, input logic [31:0] cs);
        logic [31:0] r;
        if (!md) return cs;
        r = '0;
        for (int i = 0; i < 16; i++) if (x[i]) r = r + coef(i);
        return r;
    endfunction

    assign rom_sum0 = rom_fn(x_bits0, mode, csum);
    assign rom_sum3 = rpipe[2];

    always_ff @(posedge clk) begin
        rpipe[0] <= rom_fn(x_bits3, mode, csum);
        rpipe[1] <= rpipe[0];
        rpipe[2] <= rpipe[1];
    end

    function automatic logic [15:0] plane(input int b);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = tb_slot[i][b];
        return p;
    endfunction

    function automatic logic [33:0] model(input logic md, input logic [31:0] cs, input logic [31:0] off);
        logic signed [33:0] a, s, sx;
        logic [31:0] r;
        a = '0;
        for (int b = 0; b < 16; b++) begin
            r  = rom_fn(plane(b), md, cs);
            sx = {{2{r[31]}}, r};
            if (b < 15) begin
                s = a + sx;
`ifdef OBC_SEQ_ROUND_EN
                s = s + {33'b0, s[0]};
`endif
                a = s >>> 1;
            end else begin
                a = a - sx + {{2{off[31]}}, off};
            end
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "/s_ready"}, {s_ready3, s_ready0}, 2'b11);
        chk({tag, "/m_valid"}, {m_valid3, m_valid0}, 2'b00);
        chk({tag, "/x_valid"}, {x_valid3, x_valid0}, 2'b00);
        chk({tag, "/x_bits"},  {x_bits3, x_bits0}, 32'h0);
        chk({tag, "/busy"},    {busy3, busy0}, 2'b00);
        chk({tag, "/m_data"},  {m_data3, m_data0}, 68'h0);
        chk({tag, "/state"},   {st3, st0}, 4'h0);
    endtask

    task automatic feed(input string tag);
        int n = 0;
        while (!(s_ready0 && s_ready3) && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "/ready_wait"}, {s_ready3, s_ready0}, 2'b11);
        for (int k = 0; k < 16; k++) begin
            s_valid = 1'b1;
            s_data  = tb_slot[k];
            tick();
        end
        s_valid = 1'b0;
        s_data  = 16'hDEAD;
    endtask

    // Feeds tb_slot, then follows both instances cycle by cycle (m_ready assumed high).
    task automatic run_frame(input string tag, input logic [33:0] exp);
        int lat0 = 0;
        int lat3 = 0;
        feed(tag);
        for (int c = 1; c <= 24; c++) begin
            if (c <= 16) begin
                chk({tag, "/x_valid"}, {x_valid3, x_valid0}, 2'b11);
                chk({tag, "/x_bits0"}, x_bits0, plane(c - 1));
                chk({tag, "/x_bits3"}, x_bits3, plane(c - 1));
            end
            if (c == 17) begin
                chk({tag, "/x_valid_end"}, {x_valid3, x_valid0}, 2'b00);
                chk({tag, "/x_bits_hold"}, x_bits3, plane(15));
            end
            if (m_valid0 && lat0 == 0) begin
                lat0 = c;
                chk({tag, "/m_data0"}, m_data0, exp);
            end
            if (m_valid3 && lat3 == 0) begin
                lat3 = c;
                chk({tag, "/m_data3"}, m_data3, exp);
            end
            if (lat0 != 0 && c == lat0 + 1)
                chk({tag, "/after_xfer0"}, {m_valid0, s_ready0}, 2'b01);
            if (lat3 != 0 && c == lat3 + 1)
                chk({tag, "/after_xfer3"}, {m_valid3, s_ready3}, 2'b01);
            tick();
        end
        chk({tag, "/latency0"}, 64'(lat0), 64'd17);
        chk({tag, "/latency3"}, 64'(lat3), 64'd20);
    endtask

    task automatic rand_slots();
        for (int i = 0; i < 16; i++) tb_slot[i] = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        logic [33:0] exp;
        int n;

        // 1: reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // 2: one-hot slots give one-hot planes in LSB-first order
        for (int i = 0; i < 16; i++) tb_slot[i] = 16'h0001 << i;
        mode = 1'b1;
        rom_offset = 32'h0000_1234;
        run_frame("planes", model(1'b1, 32'h0, 32'h0000_1234));

        // 3/4: constant ROM sums with hand-computed results
        mode = 1'b0;
        csum = 32'h0000_8000;
        rom_offset = 32'h0;
        run_frame("arith_m1", 34'h3_FFFF_FFFF);
        csum = 32'h0;
        rom_offset = 32'h0000_0100;
        run_frame("arith_off", 34'h0_0000_0100);

        // weighted ROM with random samples and a negative offset
        rand_slots();
        mode = 1'b1;
        rom_offset = 32'hFFF0_0321;
        run_frame("random", model(1'b1, 32'h0, 32'hFFF0_0321));

        // 5: backpressure in OUT
        rand_slots();
        rom_offset = 32'h0000_7777;
        exp = model(1'b1, 32'h0, 32'h0000_7777);
        m_ready = 1'b0;
        feed("bp");
        n = 0;
        while (!(m_valid0 && m_valid3) && n < 40) begin
            tick();
            n++;
        end
        chk("bp/m_valid_rise", {m_valid3, m_valid0}, 2'b11);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp/m_data0", m_data0, exp);
            chk("bp/m_data3", m_data3, exp);
            chk("bp/hold", {m_valid3, m_valid0, s_ready3, s_ready0, busy3, busy0}, 6'b110011);
            chk("bp/state", {st3, st0}, 4'hF);
            chk("bp/x_bits", {x_bits3, x_bits0}, {plane(15), plane(15)});
        end
        m_ready = 1'b1;
        tick();
        chk("bp/release", {m_valid3, m_valid0, s_ready3, s_ready0, busy3, busy0}, 6'b001100);

        // 6: reset in the middle of ISSUE at b=7, then a clean frame
        rand_slots();
        feed("rst_mid");
        for (int c = 0; c < 7; c++) tick();
        chk("rst_mid/plane7", x_bits0, plane(7));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset("rst_mid");
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_mid/no_stale", {m_valid3, m_valid0, x_valid3, x_valid0}, 4'b0000);
        end
        rand_slots();
        rom_offset = 32'h8000_0001;
        run_frame("after_rst", model(1'b1, 32'h0, 32'h8000_0001));

        // 7: rounding versus truncation on a tiny ROM sum
        mode = 1'b0;
        csum = 32'h1;
        rom_offset = 32'h0;
`ifdef OBC_SEQ_ROUND_EN
        run_frame("round", 34'h0);
`else
        run_frame("round", 34'h3_FFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
